// File: rtl/accel_status_pkg.sv
// ============================================================================
// Module   : accel_status_pkg
// Purpose  : Shared state codes, status-word field positions and error bit
//            indices for the accelerator status PIO block.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package accel_status_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DONE  = 3'd2,
    ST_FAULT = 3'd4
  } state_t;

  localparam int HB_BIT    = 31;
  localparam int STATE_LSB = 28;
  localparam int ERR_LSB   = 24;
  localparam int IDX_LSB   = 16;
  localparam int TIMER_LSB = 0;

  localparam int ERR_OVF      = 0;
  localparam int ERR_UNDERRUN = 1;
  localparam int ERR_DMA      = 2;
  localparam int ERR_PROTO    = 3;

endpackage

`default_nettype wire

// File: rtl/accel_status_pio_timer.sv
// ============================================================================
// Module   : accel_cycle_timer
// Purpose  : Prescaler plus 16-bit saturating layer-duration counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module accel_cycle_timer #(
  parameter int PRESCALE_LOG2 = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clear,
  input  logic        i_enable,
  output logic [15:0] o_timer
);

  logic        w_tick;
  logic [15:0] r_timer;

  generate
    if (PRESCALE_LOG2 == 0) begin : g_raw
      assign w_tick = 1'b1;
    end else begin : g_presc
      logic [PRESCALE_LOG2-1:0] r_presc;

      always_ff @(posedge clk) begin
        if (rst || i_clear) begin
          r_presc <= '0;
        end else if (i_enable) begin
          r_presc <= r_presc + 1'b1;
        end
      end

      // Timer steps on the same edge the prescaler wraps back to zero.
      assign w_tick = &r_presc;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_timer <= 16'd0;
    end else if (i_enable && w_tick && (r_timer != 16'hFFFF)) begin
      r_timer <= r_timer + 16'd1;
    end
  end

  assign o_timer = r_timer;

endmodule

`default_nettype wire

// File: rtl/accel_status_pio.sv
// ============================================================================
// Module   : accel_status_pio
// Purpose  : Layer-execution FSM, sticky error flags and packed 32-bit status
//            word for the HPS status PIO. Optional heartbeat bit enabled by
//            defining ACCEL_STATUS_HEARTBEAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module accel_status_pio
  import accel_status_pkg::*;
#(
  parameter int PRESCALE_LOG2 = 8,
  parameter int HB_LOG2       = 26
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        layer_start,
  input  logic        layer_done,
  input  logic [7:0]  layer_idx,
  input  logic [2:0]  err_in,
  input  logic        clr_err,
  output logic [31:0] status_word
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_err;
  logic [3:0]  w_err_nxt;
  logic [7:0]  r_idx;
  logic        w_idx_load;
  logic        w_tmr_clr;
  logic        w_tmr_en;
  logic [15:0] w_timer;
  logic        w_hb;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_state <= ST_IDLE;
      r_err   <= 4'd0;
      r_idx   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_err_nxt;
      if (w_idx_load) begin
        r_idx <= layer_idx;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_err_nxt   = r_err;
    w_idx_load  = 1'b0;
    w_tmr_clr   = 1'b0;
    w_tmr_en    = 1'b0;

    // Clearing first lets a coincident error pulse repopulate the flags.
    if (clr_err) begin
      w_err_nxt = 4'd0;
    end

    if (|err_in) begin
      w_err_nxt[ERR_DMA:ERR_OVF] = w_err_nxt[ERR_DMA:ERR_OVF] | err_in;
      w_state_nxt                = ST_FAULT;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (layer_start) begin
            w_state_nxt = ST_RUN;
            w_idx_load  = 1'b1;
            w_tmr_clr   = 1'b1;
          end
          if (layer_done) begin
            w_err_nxt[ERR_PROTO] = 1'b1;
          end
        end
        ST_RUN: begin
          if (layer_done) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_tmr_en = 1'b1;
          end
          if (layer_start) begin
            w_err_nxt[ERR_PROTO] = 1'b1;
          end
        end
        ST_DONE: begin
          if (layer_start) begin
            w_state_nxt = ST_RUN;
            w_idx_load  = 1'b1;
            w_tmr_clr   = 1'b1;
          end
          if (layer_done) begin
            w_err_nxt[ERR_PROTO] = 1'b1;
          end
        end
        ST_FAULT: begin
          if (clr_err) begin
            w_state_nxt = ST_IDLE;
            w_tmr_clr   = 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  accel_cycle_timer #(
    .PRESCALE_LOG2 (PRESCALE_LOG2)
  ) u_timer (
    .clk      (clk_clk),
    .rst      (reset_reset),
    .i_clear  (w_tmr_clr),
    .i_enable (w_tmr_en),
    .o_timer  (w_timer)
  );

`ifdef ACCEL_STATUS_HEARTBEAT_EN
  logic [HB_LOG2-1:0] r_hb_cnt;
  logic               r_hb;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_hb_cnt <= '0;
      r_hb     <= 1'b0;
    end else begin
      r_hb_cnt <= r_hb_cnt + 1'b1;
      if (&r_hb_cnt) begin
        r_hb <= ~r_hb;
      end
    end
  end

  assign w_hb = r_hb;
`else
  logic [31:0] w_unused_hb_log2;
  assign w_unused_hb_log2 = HB_LOG2;
  assign w_hb             = 1'b0;
`endif

  always_comb begin
    status_word                    = 32'd0;
    status_word[HB_BIT]            = w_hb;
    status_word[STATE_LSB +: 3]    = r_state;
    status_word[ERR_LSB +: 4]      = r_err;
    status_word[IDX_LSB +: 8]      = r_idx;
    status_word[TIMER_LSB +: 16]   = w_timer;
  end

endmodule

`default_nettype wire

// File: tb/tb_accel_status_pio.sv
// ============================================================================
// Module   : tb_accel_status_pio
// Purpose  : Scoreboard bench for accel_status_pio (two prescale settings).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_accel_status_pio;

  logic        clk = 1'b0;
  logic        reset_reset = 1'b1;
  logic        layer_start = 1'b0;
  logic        layer_done  = 1'b0;
  logic [7:0]  layer_idx   = 8'd0;
  logic [2:0]  err_in      = 3'd0;
  logic        clr_err     = 1'b0;
  logic [31:0] sw_a;
  logic [31:0] sw_b;

  typedef struct {
    string       name;
    bit          which;
    logic [31:0] exp;
  } sb_entry_t;

  sb_entry_t sb[$];
  int        n_checks = 0;
  int        n_fail   = 0;
  int        m_cycles = 0;

  always #5 clk = ~clk;

  // Instance A: prescale by 4, fast heartbeat. Instance B: raw cycle count.
  accel_status_pio #(.PRESCALE_LOG2(2), .HB_LOG2(3)) dut_a (
    .clk_clk(clk), .reset_reset(reset_reset), .layer_start(layer_start),
    .layer_done(layer_done), .layer_idx(layer_idx), .err_in(err_in),
    .clr_err(clr_err), .status_word(sw_a)
  );

  accel_status_pio #(.PRESCALE_LOG2(0)) dut_b (
    .clk_clk(clk), .reset_reset(reset_reset), .layer_start(layer_start),
    .layer_done(layer_done), .layer_idx(layer_idx), .err_in(err_in),
    .clr_err(clr_err), .status_word(sw_b)
  );

  always @(posedge clk) begin
    if (reset_reset) m_cycles <= 0;
    else             m_cycles <= m_cycles + 1;
  end

  function automatic logic hb_exp(input bit which);
    if (which) return 1'b0;
`ifdef ACCEL_STATUS_HEARTBEAT_EN
    return m_cycles[3];
`else
    return 1'b0;
`endif
  endfunction

  task automatic push(input string name, input bit which, input logic [31:0] exp);
    sb_entry_t e;
    e.name  = name;
    e.which = which;
    e.exp   = {hb_exp(which), exp[30:0]};
    sb.push_back(e);
  endtask

  task automatic push2(input string name, input logic [31:0] ea, input logic [31:0] eb);
    push({name, "_a"}, 1'b0, ea);
    push({name, "_b"}, 1'b1, eb);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic st, input logic dn, input logic [7:0] idx,
                       input logic [2:0] er, input logic clr);
    layer_start = st; layer_done = dn; layer_idx = idx; err_in = er; clr_err = clr;
    tick();
    layer_start = 1'b0; layer_done = 1'b0; err_in = 3'd0; clr_err = 1'b0;
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      sb_entry_t e;
      logic [31:0] act;
      e   = sb.pop_front();
      act = e.which ? sw_b : sw_a;
      n_checks++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
    end
  end

  initial begin
    repeat (3) tick();
    push2("reset", 32'h0000_0000, 32'h0000_0000);
    reset_reset = 1'b0;
    repeat (10) tick();
    push2("idle10", 32'h0000_0000, 32'h0000_0000);

    // Layer 0x2A: 40 running cycles, then done.
    pulse(1'b1, 1'b0, 8'h2A, 3'd0, 1'b0);
    push2("start", 32'h102A_0000, 32'h102A_0000);
    repeat (40) tick();
    push2("run_end", 32'h102A_000A, 32'h102A_0028);
    pulse(1'b0, 1'b1, 8'h00, 3'd0, 1'b0);
    push2("done", 32'h202A_000A, 32'h202A_0028);
    repeat (5) tick();
    push2("done_hold", 32'h202A_000A, 32'h202A_0028);

    // Long layer: B saturates, A (divide by 4) does not.
    pulse(1'b1, 1'b0, 8'h05, 3'd0, 1'b0);
    push2("restart", 32'h1005_0000, 32'h1005_0000);
    repeat (70000) tick();
    push2("sat", 32'h1005_445C, 32'h1005_FFFF);
    repeat (100) tick();
    push2("sat_hold", 32'h1005_4475, 32'h1005_FFFF);

    // DMA error in RUN, start/done ignored in FAULT, heartbeat keeps going.
    pulse(1'b0, 1'b0, 8'h00, 3'b100, 1'b0);
    push2("fault", 32'h4405_4475, 32'h4405_FFFF);
    pulse(1'b1, 1'b1, 8'hEE, 3'd0, 1'b0);
    push2("fault_ign", 32'h4405_4475, 32'h4405_FFFF);
    for (int i = 0; i < 16; i++) begin
      tick();
      push("fault_hb", 1'b0, 32'h4405_4475);
    end
    pulse(1'b0, 1'b0, 8'h00, 3'd0, 1'b1);
    push2("clr", 32'h0005_0000, 32'h0005_0000);
    pulse(1'b0, 1'b0, 8'h00, 3'b001, 1'b1);
    push2("clr_err_same", 32'h4105_0000, 32'h4105_0000);
    pulse(1'b0, 1'b0, 8'h00, 3'd0, 1'b1);
    push2("clr2", 32'h0005_0000, 32'h0005_0000);

    // Start+done together in RUN, then done in DONE.
    pulse(1'b1, 1'b0, 8'h77, 3'd0, 1'b0);
    repeat (3) tick();
    push2("run3", 32'h1077_0000, 32'h1077_0003);
    pulse(1'b1, 1'b1, 8'h99, 3'd0, 1'b0);
    push2("st_dn", 32'h2877_0000, 32'h2877_0003);
    pulse(1'b0, 1'b1, 8'h00, 3'd0, 1'b0);
    push2("dn_in_done", 32'h2877_0000, 32'h2877_0003);
    pulse(1'b0, 1'b0, 8'h00, 3'd0, 1'b1);
    push2("clr_in_done", 32'h2077_0000, 32'h2077_0003);

    // Mid-layer reset drops everything.
    pulse(1'b1, 1'b0, 8'h12, 3'd0, 1'b0);
    repeat (9) tick();
    reset_reset = 1'b1;
    tick();
    push2("reset_mid", 32'h0000_0000, 32'h0000_0000);
    reset_reset = 1'b0;

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
